// File: rtl/countdown_share_arbiter_if.sv
// Handshake bundle between client FSMs and the shared countdown sequencer.
// The client side drives requests and start values; the arbiter side returns ownership and status.
interface countdown_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] load_val;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic [WIDTH-1:0]       count;
    logic                   busy;

    modport master (
        output req,
        output load_val,
        input  grant,
        input  done,
        input  count,
        input  busy
    );

    modport slave (
        input  req,
        input  load_val,
        output grant,
        output done,
        output count,
        output busy
    );
endinterface

// File: rtl/countdown_share_arbiter.sv
// Round-robin sequencer sharing one down counter among N_REQ requesters.
// The winner's start value is loaded, counted to zero, and a done pulse is returned to it.
module countdown_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    countdown_share_arbiter_if.slave     bus
);
    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;

    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    int                 cand;
    logic [WIDTH-1:0]   owner_val;
    logic               owner_req;

    assign owner_val = bus.load_val[owner_q*WIDTH +: WIDTH];
    assign owner_req = bus.req[owner_q];

    // Search starts just past the previous owner, so it becomes lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last_q) + i) % N_REQ;
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        count_d = count_q;
        owner_d = owner_q;
        last_d  = last_q;

        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_d = N_REQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!owner_req) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    count_d = '0;
                    last_d  = owner_q;
                end else begin
                    count_d = owner_val;
                    if (owner_val == '0) begin
                        state_d = S_DONE;
                        done_d  = grant_q;
                    end else begin
                        state_d = S_COUNT;
                    end
                end
            end
            S_COUNT: begin
                if (!owner_req) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    count_d = '0;
                    last_d  = owner_q;
                end else if (count_q <= WIDTH'(1)) begin
                    // Finishing at one rather than zero keeps the counter from ever wrapping.
                    count_d = '0;
                    state_d = S_DONE;
                    done_d  = grant_q;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            S_DONE: begin
                grant_d = '0;
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                count_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_countdown_share_arbiter.sv
// Directed bench for countdown_share_arbiter; done pulses are scored against a queue of
// expected (owner, cycle) entries pushed when each request is driven.
module tb_countdown_share_arbiter;
    localparam int N_REQ = 4;
    localparam int WIDTH = 4;

    typedef struct {
        logic [N_REQ-1:0] done;
        int               cyc;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   g;
    logic [N_REQ-1:0] prev_done;
    exp_t sb_q[$];

    countdown_share_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) ifc ();

    countdown_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; invariants checked every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check("inv_grant_onehot0", 32'($onehot0(ifc.grant)), 32'd1);
        check("inv_done_subset",   32'(ifc.done & ~ifc.grant), 32'd0);
        check("inv_idle_no_grant", 32'(!ifc.busy && (ifc.grant != '0)), 32'd0);
        check("inv_done_consec",   32'((prev_done != '0) && (ifc.done != '0)), 32'd0);
        prev_done = ifc.done;
    endtask

    task automatic sb_push(input logic [N_REQ-1:0] d, input int c);
        exp_t e;
        e.done = d;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    task automatic sb_wait(input string tag, input int budget);
        exp_t e;
        int   n;
        n = 0;
        do begin
            tick();
            n++;
        end while (ifc.done == '0 && n < budget);
        n_cmp++;
        assert (sb_q.size() != 0) else begin
            n_err++;
            $error("FAIL %s_sb_empty observed=%0d expected=nonzero", tag, sb_q.size());
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check({tag, "_done"},  32'(ifc.done), 32'(e.done));
            check({tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, 32'(ifc.grant), 32'd0);
        check({tag, "_done"},  32'(ifc.done),  32'd0);
        check({tag, "_count"}, 32'(ifc.count), 32'd0);
        check({tag, "_busy"},  32'(ifc.busy),  32'd0);
    endtask

    task automatic do_reset();
        ifc.req = '0;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        prev_done = '0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        cyc       = 0;
        prev_done = '0;
        reset_n   = 1'b0;
        ifc.req      = '0;
        ifc.load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        reset_n = 1'b1;

        // Single requester, start value 3.
        ifc.load_val[0*WIDTH +: WIDTH] = 4'd3;
        ifc.req = 4'b0001;
        sb_push(4'b0001, cyc + 5);
        tick();
        check("t1_grant", 32'(ifc.grant), 32'h1);
        check("t1_busy",  32'(ifc.busy),  32'h1);
        for (int v = 3; v >= 1; v--) begin
            tick();
            check("t1_count", 32'(ifc.count), 32'(v));
            check("t1_no_done", 32'(ifc.done), 32'd0);
        end
        sb_wait("t1", 10);
        check("t1_count_zero", 32'(ifc.count), 32'd0);
        ifc.req = '0;
        tick();
        check_idle("t1_back_idle");

        // All four requesting, each slice 1: strict round-robin order from requester 0.
        do_reset();
        for (int i = 0; i < N_REQ; i++) ifc.load_val[i*WIDTH +: WIDTH] = 4'd1;
        ifc.req = 4'b1111;
        sb_push(4'b0001, cyc + 3);
        sb_push(4'b0010, cyc + 7);
        sb_push(4'b0100, cyc + 11);
        sb_push(4'b1000, cyc + 15);
        sb_push(4'b0001, cyc + 19);
        for (int k = 0; k < 5; k++) sb_wait("t2_rr", 20);
        ifc.req = '0;
        tick();
        check_idle("t2_back_idle");

        // Zero start value: LOAD goes straight to DONE.
        ifc.load_val[2*WIDTH +: WIDTH] = 4'd0;
        ifc.req = 4'b0100;
        sb_push(4'b0100, cyc + 2);
        tick();
        check("t3_grant", 32'(ifc.grant), 32'h4);
        sb_wait("t3", 10);
        check("t3_count", 32'(ifc.count), 32'd0);
        ifc.req = '0;
        tick();
        check_idle("t3_back_idle");

        // Owner 1 withdraws at count 9; pending requester 3 is served next.
        ifc.load_val[1*WIDTH +: WIDTH] = 4'd15;
        ifc.load_val[3*WIDTH +: WIDTH] = 4'd2;
        ifc.req = 4'b0010;
        tick();
        check("t4_grant1", 32'(ifc.grant), 32'h2);
        ifc.req = 4'b1010;
        tick();
        check("t4_count15", 32'(ifc.count), 32'd15);
        repeat (6) tick();
        check("t4_count9", 32'(ifc.count), 32'd9);
        ifc.req = 4'b1000;
        tick();
        check_idle("t4_withdraw");
        tick();
        check("t4_grant3", 32'(ifc.grant), 32'h8);
        g = cyc;
        sb_push(4'b1000, g + 3);
        sb_wait("t4_pending", 10);
        ifc.req = '0;
        tick();

        // Asynchronous reset in the middle of a count.
        ifc.load_val[0*WIDTH +: WIDTH] = 4'd10;
        ifc.req = 4'b0001;
        tick();
        check("t5_grant", 32'(ifc.grant), 32'h1);
        tick();
        repeat (4) tick();
        check("t5_count6", 32'(ifc.count), 32'd6);
        reset_n = 1'b0;
        #1;
        check_idle("t5_async_reset");
        ifc.req = 4'b0011;
        ifc.load_val[0*WIDTH +: WIDTH] = 4'd1;
        ifc.load_val[1*WIDTH +: WIDTH] = 4'd1;
        #1;
        reset_n = 1'b1;
        prev_done = '0;
        tick();
        check("t5_grant_after_reset", 32'(ifc.grant), 32'h1);
        g = cyc;
        sb_push(4'b0001, g + 2);
        sb_wait("t5", 10);
        ifc.req = '0;
        tick();

        // Maximum start value; load_val changes after LOAD must not matter.
        ifc.load_val[0*WIDTH +: WIDTH] = 4'd15;
        ifc.req = 4'b0001;
        sb_push(4'b0001, cyc + 17);
        tick();
        check("t6_grant", 32'(ifc.grant), 32'h1);
        tick();
        check("t6_count15", 32'(ifc.count), 32'd15);
        ifc.load_val[0*WIDTH +: WIDTH] = 4'd5;
        sb_wait("t6", 40);
        check("t6_count_zero", 32'(ifc.count), 32'd0);
        ifc.req = '0;
        repeat (3) begin
            tick();
            check("t6_no_wrap", 32'(ifc.count), 32'd0);
        end

        n_cmp++;
        assert (sb_q.size() == 0) else begin
            n_err++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
